// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned IF_ID_BUS_W = 2 * XLEN + 1;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h1c00_0000;
   localparam logic [1:0]      SRAM_SIZE_WORD   = 2'b10;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic            adef;
      logic            filled;
   } fetch_entry_t;

   function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/if_ibuf.sv
// In-order fetch queue: entries are reserved at issue (alloc), completed in
// allocation order (fill) and retired from the head (deq).
module if_ibuf
   import if_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   clear,
   input  logic                   alloc,
   input  logic [XLEN-1:0]        alloc_pc,
   input  logic                   alloc_adef,
   input  logic                   fill,
   input  logic [XLEN-1:0]        fill_inst,
   input  logic                   deq,
   output logic                   head_filled,
   output logic [IF_ID_BUS_W-1:0] head_bus,
   output logic [CNT_W-1:0]       count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t     entries [DEPTH];
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [PTR_W-1:0] fill_q;
   logic [CNT_W-1:0] count_q;

   // Entry storage; an address-error entry is complete the moment it is allocated.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[PTR_W'(i)] <= '0;
         end
      end else if (clear) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[PTR_W'(i)].filled <= 1'b0;
         end
      end else begin
         if (deq) begin
            entries[head_q].filled <= 1'b0;
         end
         if (alloc) begin
            entries[tail_q].pc     <= alloc_pc;
            entries[tail_q].inst   <= '0;
            entries[tail_q].adef   <= alloc_adef;
            entries[tail_q].filled <= alloc_adef;
         end
         if (fill) begin
            entries[fill_q].inst   <= fill_inst;
            entries[fill_q].filled <= 1'b1;
         end
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         fill_q  <= '0;
         count_q <= '0;
      end else if (clear) begin
         head_q  <= '0;
         tail_q  <= '0;
         fill_q  <= '0;
         count_q <= '0;
      end else begin
         if (alloc) tail_q <= tail_q + PTR_W'(1);
         if (deq)   head_q <= head_q + PTR_W'(1);
         if (fill)  fill_q <= fill_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(alloc) - CNT_W'(deq);
      end
   end

   assign head_filled = entries[head_q].filled;
   assign head_bus    = {entries[head_q].adef, entries[head_q].pc, entries[head_q].inst};
   assign count       = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: PC generation, pipelined SRAM-like requests,
// stale-response discard after redirects and misaligned-fetch tagging.
module if_fetch_queue
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
   parameter int unsigned IBUF_DEPTH      = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned CNT_W           = $clog2(IBUF_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush_valid,
   input  logic [31:0]      flush_pc,
   input  logic             br_taken,
   input  logic [31:0]      br_target,
   input  logic             br_stall,
   input  logic             id_allowin,
   output logic             if_id_valid,
   output logic [31:0]      if_id_pc,
   output logic [31:0]      if_id_inst,
   output logic             if_id_adef,
   output logic             inst_sram_req,
   output logic             inst_sram_wr,
   output logic [1:0]       inst_sram_size,
   output logic [3:0]       inst_sram_wstrb,
   output logic [31:0]      inst_sram_addr,
   output logic [31:0]      inst_sram_wdata,
   input  logic             inst_sram_addr_ok,
   input  logic             inst_sram_data_ok,
   input  logic [31:0]      inst_sram_rdata,
   output logic [CNT_W-1:0] ibuf_count
);

   localparam int unsigned SUM_W = CNT_W + 1;

   logic [31:0]            fetch_pc_q;
   logic                   halted_q;
   logic                   run_q;
   logic [CNT_W-1:0]       outstanding_q;
   logic [CNT_W-1:0]       discard_q;

   logic                   redirect_c;
   logic [31:0]            target_c;
   logic                   aligned_c;
   logic                   space_c;
   logic                   credit_c;
   logic                   issue_c;
   logic                   misalign_c;
   logic                   accept_c;
   logic                   drop_c;
   logic                   fill_c;
   logic                   deq_c;
   logic                   head_filled;
   logic [IF_ID_BUS_W-1:0] head_bus;

   always_comb begin
      redirect_c = flush_valid | br_taken;
      target_c   = flush_valid ? flush_pc : br_target;
      aligned_c  = is_word_aligned(fetch_pc_q);
      space_c    = ibuf_count < CNT_W'(IBUF_DEPTH);
      // Stale requests still on the bus consume issue credit until they drain.
      credit_c   = (SUM_W'(outstanding_q) + SUM_W'(discard_q)) < SUM_W'(MAX_OUTSTANDING);
      issue_c    = run_q & ~redirect_c & ~br_stall & ~halted_q & aligned_c & space_c & credit_c;
      misalign_c = run_q & ~redirect_c & ~halted_q & ~aligned_c & space_c;
      accept_c   = issue_c & inst_sram_addr_ok;
      drop_c     = inst_sram_data_ok & (redirect_c | (discard_q != '0));
      fill_c     = inst_sram_data_ok & ~drop_c;
      deq_c      = if_id_valid & id_allowin;
   end

   // Holds requests off until the first cycle after reset release.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         run_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fetch_pc_q <= RESET_PC;
         halted_q   <= 1'b0;
      end else if (redirect_c) begin
         fetch_pc_q <= target_c;
         halted_q   <= 1'b0;
      end else if (accept_c) begin
         fetch_pc_q <= fetch_pc_q + 32'd4;
      end else if (misalign_c) begin
         halted_q   <= 1'b1;
      end
   end

   // A redirect turns every live request into a stale one; a response in the
   // same cycle belongs to the oldest request and is dropped.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         outstanding_q <= '0;
         discard_q     <= '0;
      end else if (redirect_c) begin
         outstanding_q <= '0;
         discard_q     <= discard_q + outstanding_q - CNT_W'(inst_sram_data_ok);
      end else begin
         outstanding_q <= outstanding_q + CNT_W'(accept_c) - CNT_W'(fill_c);
         discard_q     <= discard_q - CNT_W'(drop_c);
      end
   end

   if_ibuf #(
      .DEPTH (IBUF_DEPTH),
      .CNT_W (CNT_W)
   ) u_ibuf (
      .clk         (clk),
      .resetn      (resetn),
      .clear       (redirect_c),
      .alloc       (accept_c | misalign_c),
      .alloc_pc    (fetch_pc_q),
      .alloc_adef  (misalign_c),
      .fill        (fill_c),
      .fill_inst   (inst_sram_rdata),
      .deq         (deq_c),
      .head_filled (head_filled),
      .head_bus    (head_bus),
      .count       (ibuf_count)
   );

   assign if_id_valid     = head_filled & ~redirect_c;
   assign if_id_adef      = head_bus[IF_ID_BUS_W-1];
   assign if_id_pc        = head_bus[2*XLEN-1:XLEN];
   assign if_id_inst      = head_bus[XLEN-1:0];

   assign inst_sram_req   = issue_c;
   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = SRAM_SIZE_WORD;
   assign inst_sram_wstrb = 4'h0;
   assign inst_sram_addr  = fetch_pc_q;
   assign inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a small in-order instruction bus model.
module tb_if_fetch_queue;

   localparam logic [31:0] KEY = 32'hA5A5_0000;
   localparam logic [31:0] RPC = 32'h1c00_0000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush_valid, br_taken, br_stall, id_allowin;
   logic [31:0] flush_pc, br_target;
   logic        if_id_valid, if_id_adef;
   logic [31:0] if_id_pc, if_id_inst;
   logic        inst_sram_req, inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr, inst_sram_wdata;
   logic        inst_sram_addr_ok, inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic [2:0]  ibuf_count;

   int checks = 0;
   int errors = 0;

   int          cyc = 0;
   int          bus_lat = 1;
   logic [31:0] bus_a[$];
   int          bus_t[$];
   logic [31:0] iss_q[$];
   int          iss_cyc[$];
   logic [31:0] dl_pc[$];
   logic [31:0] dl_inst[$];
   logic [31:0] dl_adef[$];

   int m, dm, rcyc;

   if_fetch_queue dut (
      .clk               (clk),
      .resetn            (resetn),
      .flush_valid       (flush_valid),
      .flush_pc          (flush_pc),
      .br_taken          (br_taken),
      .br_target         (br_target),
      .br_stall          (br_stall),
      .id_allowin        (id_allowin),
      .if_id_valid       (if_id_valid),
      .if_id_pc          (if_id_pc),
      .if_id_inst        (if_id_inst),
      .if_id_adef        (if_id_adef),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_wr      (inst_sram_wr),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_wstrb   (inst_sram_wstrb),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_wdata   (inst_sram_wdata),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .ibuf_count        (ibuf_count)
   );

   always #5 clk = ~clk;

   // Bus model and event logger: decides the response for the coming edge,
   // then records what the DUT will hand over at that edge.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!resetn) begin
         bus_a.delete();
         bus_t.delete();
         inst_sram_data_ok = 1'b0;
         inst_sram_rdata   = 32'h0;
      end else begin
         if (bus_a.size() > 0 && (cyc - bus_t[0]) >= bus_lat) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = bus_a[0] ^ KEY;
            bus_a.delete(0);
            bus_t.delete(0);
         end else begin
            inst_sram_data_ok = 1'b0;
            inst_sram_rdata   = 32'h0;
         end
         if (inst_sram_req && inst_sram_addr_ok) begin
            bus_a.push_back(inst_sram_addr);
            bus_t.push_back(cyc);
            iss_q.push_back(inst_sram_addr);
            iss_cyc.push_back(cyc);
         end
         if (if_id_valid && id_allowin) begin
            dl_pc.push_back(if_id_pc);
            dl_inst.push_back(if_id_inst);
            dl_adef.push_back(32'(if_id_adef));
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
      if (i >= 0 && i < q.size()) return q[i];
      return 32'hxxxx_xxxx;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      resetn      = 1'b0;
      flush_valid = 1'b0;
      br_taken    = 1'b0;
      br_stall    = 1'b0;
      inst_sram_addr_ok = 1'b1;
      step(2);
      resetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0;
      flush_valid = 1'b0; flush_pc = 32'h0;
      br_taken = 1'b0; br_target = 32'h0; br_stall = 1'b0;
      id_allowin = 1'b1;
      inst_sram_addr_ok = 1'b1;
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
      step(2);

      // Reset state
      chk("rst_valid", 32'(if_id_valid), 32'd0);
      chk("rst_req",   32'(inst_sram_req), 32'd0);
      chk("rst_count", 32'(ibuf_count), 32'd0);
      chk("const_bus", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata[22:0]},
          {1'b0, 2'b10, 4'h0, 23'h0});

      // 1: streaming with immediate responses
      bus_lat = 1; id_allowin = 1'b1;
      m = iss_q.size(); dm = dl_pc.size();
      do_reset();
      step(8);
      chk("t1_iss0", qget(iss_q, m),     RPC);
      chk("t1_iss1", qget(iss_q, m + 1), RPC + 32'd4);
      chk("t1_iss2", qget(iss_q, m + 2), RPC + 32'd8);
      chk("t1_b2b",  32'(iss_cyc[m + 2] - iss_cyc[m]), 32'd2);
      chk("t1_dpc0", qget(dl_pc, dm),     RPC);
      chk("t1_dpc1", qget(dl_pc, dm + 1), RPC + 32'd4);
      chk("t1_dpc2", qget(dl_pc, dm + 2), RPC + 32'd8);
      chk("t1_din2", qget(dl_inst, dm + 2), (RPC + 32'd8) ^ KEY);
      chk("t1_req_run", 32'(inst_sram_req), 32'd1);
      br_stall = 1'b1;
      #1;
      chk("t1_req_stall", 32'(inst_sram_req), 32'd0);
      br_stall = 1'b0;

      // 2: ID back-pressure fills the queue, then drains in order
      id_allowin = 1'b0;
      m = iss_q.size(); dm = dl_pc.size();
      do_reset();
      step(12);
      chk("t2_count", 32'(ibuf_count), 32'd4);
      chk("t2_req",   32'(inst_sram_req), 32'd0);
      chk("t2_niss",  32'(iss_q.size() - m), 32'd4);
      chk("t2_head",  if_id_pc, RPC);
      id_allowin = 1'b1;
      step(12);
      chk("t2_dpc0", qget(dl_pc, dm),     RPC);
      chk("t2_dpc1", qget(dl_pc, dm + 1), RPC + 32'd4);
      chk("t2_dpc2", qget(dl_pc, dm + 2), RPC + 32'd8);
      chk("t2_dpc3", qget(dl_pc, dm + 3), RPC + 32'd12);
      chk("t2_din3", qget(dl_inst, dm + 3), (RPC + 32'd12) ^ KEY);
      chk("t2_resume", qget(iss_q, m + 4), RPC + 32'd16);

      // 3: branch with two requests in flight; stale responses discarded
      bus_lat = 100; id_allowin = 1'b1;
      do_reset();
      step(6);
      chk("t3_pending", 32'(ibuf_count), 32'd2);
      chk("t3_req_full", 32'(inst_sram_req), 32'd0);
      m = iss_q.size(); dm = dl_pc.size(); rcyc = cyc;
      br_taken = 1'b1; br_target = 32'h1c00_0100;
      #1;
      chk("t3_valid_redir", 32'(if_id_valid), 32'd0);
      step(1);
      br_taken = 1'b0;
      bus_lat = 3;
      step(15);
      chk("t3_iss0", qget(iss_q, m), 32'h1c00_0100);
      chk("t3_wait", 32'(iss_cyc[m] >= rcyc + 3), 32'd1);
      chk("t3_dpc0", qget(dl_pc, dm), 32'h1c00_0100);
      chk("t3_din0", qget(dl_inst, dm), 32'h1c00_0100 ^ KEY);

      // 4: flush and branch together; flush wins
      bus_lat = 1; id_allowin = 1'b1;
      do_reset();
      step(6);
      m = iss_q.size(); dm = dl_pc.size();
      flush_valid = 1'b1; flush_pc = 32'h1c00_8000;
      br_taken = 1'b1; br_target = 32'h1c00_0200;
      step(1);
      flush_valid = 1'b0; br_taken = 1'b0;
      step(10);
      chk("t4_iss0", qget(iss_q, m), 32'h1c00_8000);
      chk("t4_dpc0", qget(dl_pc, dm), 32'h1c00_8000);

      // 5: misaligned branch target yields an address-error entry and halts
      bus_lat = 1; id_allowin = 1'b0;
      do_reset();
      step(3);
      br_taken = 1'b1; br_target = 32'h1c00_0102;
      m = iss_q.size();
      step(1);
      br_taken = 1'b0;
      step(8);
      chk("t5_valid", 32'(if_id_valid), 32'd1);
      chk("t5_pc",    if_id_pc, 32'h1c00_0102);
      chk("t5_adef",  32'(if_id_adef), 32'd1);
      chk("t5_inst",  if_id_inst, 32'h0);
      chk("t5_count", 32'(ibuf_count), 32'd1);
      chk("t5_req",   32'(inst_sram_req), 32'd0);
      chk("t5_niss",  32'(iss_q.size() - m), 32'd0);
      flush_valid = 1'b1; flush_pc = 32'h1c00_8000; id_allowin = 1'b1;
      dm = dl_pc.size();
      step(1);
      flush_valid = 1'b0;
      step(6);
      chk("t5_iss0",  qget(iss_q, m), 32'h1c00_8000);
      chk("t5_dpc0",  qget(dl_pc, dm), 32'h1c00_8000);
      chk("t5_dadef", qget(dl_adef, dm), 32'd0);

      // 6: asynchronous reset mid-burst
      bus_lat = 100; id_allowin = 1'b1;
      do_reset();
      step(6);
      chk("t6_pending", 32'(ibuf_count), 32'd2);
      resetn = 1'b0;
      #1;
      chk("t6_req",   32'(inst_sram_req), 32'd0);
      chk("t6_valid", 32'(if_id_valid), 32'd0);
      chk("t6_count", 32'(ibuf_count), 32'd0);
      step(2);
      bus_lat = 1;
      m = iss_q.size(); dm = dl_pc.size();
      resetn = 1'b1;
      step(6);
      chk("t6_iss0", qget(iss_q, m), RPC);
      chk("t6_dpc0", qget(dl_pc, dm), RPC);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
